// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer: same-cycle lookup, update trains entries, registered mispredict pulse/count.
// Zero-latency lookup, one-cycle update and mispredict; no backpressure. Define BTB_2BIT_CNT_EN for 2-bit counters.
module btb_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              prediction_o,
  output logic              hit_o,
  output logic [ADDR_W-1:0] target_pc_o,
  input  logic              upd_en_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  input  logic              flush_i,
  output logic              mispredict_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

`ifdef BTB_2BIT_CNT_EN
  localparam int              CTR_W     = 2;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
  localparam logic [CTR_W-1:0] CTR_RST   = 2'b01;
`else
  localparam int              CTR_W     = 1;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
  localparam logic [CTR_W-1:0] CTR_RST   = 1'b0;
`endif
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];
  logic               r_mispredict;
  logic [CNT_W-1:0]   r_mis_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic             w_mis;
  logic             w_unused_lsbs;

  assign w_idx  = pc_i[IDX_W+1:2];
  assign w_tag  = pc_i[ADDR_W-1:IDX_W+2];
  assign w_uidx = upd_pc_i[IDX_W+1:2];
  assign w_utag = upd_pc_i[ADDR_W-1:IDX_W+2];
  // Byte offset within the instruction word never selects an entry.
  assign w_unused_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign hit_o        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign prediction_o = hit_o && r_ctr[w_idx][CTR_W-1];
  assign target_pc_o  = prediction_o ? r_target[w_idx] : '0;

  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_mis  = (upd_taken_i != upd_pred_i) ||
                  (upd_taken_i && upd_pred_i && (upd_target_i != upd_pred_target_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_mispredict <= 1'b0;
      r_mis_cnt    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RST;
      end
    end else begin
      if (upd_en_i) begin
        if (upd_taken_i) begin
          r_target[w_uidx] <= upd_target_i;
          if (w_uhit) begin
            if (r_ctr[w_uidx] != CTR_MAX)
              r_ctr[w_uidx] <= r_ctr[w_uidx] + 1'b1;
          end else begin
            r_valid[w_uidx] <= 1'b1;
            r_tag[w_uidx]   <= w_utag;
            r_ctr[w_uidx]   <= CTR_ALLOC;
          end
        end else if (w_uhit && (r_ctr[w_uidx] != '0)) begin
          r_ctr[w_uidx] <= r_ctr[w_uidx] - 1'b1;
        end
      end
      // Flush overrides any allocation made by a coincident update.
      if (flush_i)
        r_valid <= '0;
      r_mispredict <= upd_en_i && w_mis;
      if (upd_en_i && w_mis && (r_mis_cnt != '1))
        r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  assign mispredict_o     = r_mispredict;
  assign mispredict_cnt_o = r_mis_cnt;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed scoreboard bench for btb_predictor (ENTRIES=8, CNT_W=4 so the count saturates quickly).
module tb_btb_predictor;

`ifdef BTB_2BIT_CNT_EN
  localparam bit TWO_BIT = 1'b1;
`else
  localparam bit TWO_BIT = 1'b0;
`endif
  localparam int CNT_MAX = 15;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        prediction_o;
  logic        hit_o;
  logic [31:0] target_pc_o;
  logic        upd_en_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_i;
  logic [31:0] upd_pred_target_i;
  logic        flush_i;
  logic        mispredict_o;
  logic [3:0]  mispredict_cnt_o;

  btb_predictor #(.ADDR_W(32), .ENTRIES(8), .CNT_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc_i),
    .prediction_o      (prediction_o),
    .hit_o             (hit_o),
    .target_pc_o       (target_pc_o),
    .upd_en_i          (upd_en_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_i        (upd_pred_i),
    .upd_pred_target_i (upd_pred_target_i),
    .flush_i           (flush_i),
    .mispredict_o      (mispredict_o),
    .mispredict_cnt_o  (mispredict_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  exp_cnt     = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0h, expected an entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h, expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic hit, input logic pred,
                        input logic [31:0] tgt);
    pc_i = pc;
    push($sformatf("hit_o@%0h", pc), {31'd0, hit});
    push($sformatf("prediction_o@%0h", pc), {31'd0, pred});
    push($sformatf("target_pc_o@%0h", pc), tgt);
    #1;
    pop_check({31'd0, hit_o});
    pop_check({31'd0, prediction_o});
    pop_check(target_pc_o);
  endtask

  task automatic expect_mis(input logic mis);
    if (mis && exp_cnt != CNT_MAX) exp_cnt++;
    push("mispredict_o", {31'd0, mis});
    push("mispredict_cnt_o", exp_cnt);
  endtask

  task automatic check_mis();
    pop_check({31'd0, mispredict_o});
    pop_check({28'd0, mispredict_cnt_o});
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic pred, input logic [31:0] ptgt, input logic flush,
                           input logic exp_mis);
    upd_en_i          = 1'b1;
    upd_pc_i          = pc;
    upd_taken_i       = taken;
    upd_target_i      = tgt;
    upd_pred_i        = pred;
    upd_pred_target_i = ptgt;
    flush_i           = flush;
    expect_mis(exp_mis);
    @(posedge clk);
    #1;
    upd_en_i = 1'b0;
    flush_i  = 1'b0;
    check_mis();
  endtask

  task automatic idle_cycle();
    upd_en_i = 1'b0;
    flush_i  = 1'b0;
    expect_mis(1'b0);
    @(posedge clk);
    #1;
    check_mis();
  endtask

  initial begin
    rst = 1'b1;
    pc_i = 32'h0;
    upd_en_i = 1'b0;
    upd_pc_i = 32'h0;
    upd_taken_i = 1'b0;
    upd_target_i = 32'h0;
    upd_pred_i = 1'b0;
    upd_pred_target_i = 32'h0;
    flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    expect_mis(1'b0);
    check_mis();
    lookup(32'h100, 1'b0, 1'b0, 32'h0);

    // First allocation, predicted not-taken: mispredict.
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b1);
    lookup(32'h100, 1'b1, 1'b1, 32'h200);
    idle_cycle();

    // Two not-taken updates.
    do_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b1);
    lookup(32'h100, 1'b1, 1'b0, 32'h0);
    do_update(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    lookup(32'h100, 1'b1, 1'b0, 32'h0);

    // Alias at the same index replaces the entry.
    do_update(32'h120, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b1);
    lookup(32'h100, 1'b0, 1'b0, 32'h0);
    lookup(32'h120, 1'b1, 1'b1, 32'h400);

    // Direction right, target wrong.
    do_update(32'h120, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b1);
    lookup(32'h120, 1'b1, 1'b1, 32'h300);
    do_update(32'h120, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0);
    lookup(32'h123, 1'b1, 1'b1, 32'h300);

    // One not-taken after strong taken: 2-bit build keeps predicting taken.
    do_update(32'h120, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b1);
    lookup(32'h120, 1'b1, TWO_BIT, TWO_BIT ? 32'h300 : 32'h0);

    // Not-taken miss leaves the entry invalid.
    do_update(32'h1A4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    lookup(32'h1A4, 1'b0, 1'b0, 32'h0);

    // Lookup during the update of the same index sees pre-update state.
    pc_i = 32'h164;
    upd_en_i = 1'b1;
    upd_pc_i = 32'h164;
    upd_taken_i = 1'b1;
    upd_target_i = 32'h500;
    upd_pred_i = 1'b0;
    upd_pred_target_i = 32'h0;
    push("hit_o_same_cycle", 32'd0);
    #1;
    pop_check({31'd0, hit_o});
    expect_mis(1'b1);
    @(posedge clk);
    #1;
    upd_en_i = 1'b0;
    check_mis();
    lookup(32'h164, 1'b1, 1'b1, 32'h500);

    // Disabled update with conflicting inputs is ignored.
    upd_pc_i = 32'h164;
    upd_taken_i = 1'b0;
    upd_pred_i = 1'b1;
    idle_cycle();
    lookup(32'h164, 1'b1, 1'b1, 32'h500);

    // Flush wins over a coincident allocation; pulse still issued.
    do_update(32'h140, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b1);
    lookup(32'h140, 1'b0, 1'b0, 32'h0);
    lookup(32'h120, 1'b0, 1'b0, 32'h0);
    lookup(32'h164, 1'b0, 1'b0, 32'h0);

    // Back-to-back mispredicts drive the count into saturation.
    for (int i = 0; i < 12; i++)
      do_update(32'h180, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 1'b1);
    idle_cycle();

    // Reset during an update drops the update.
    rst = 1'b1;
    upd_en_i = 1'b1;
    upd_pc_i = 32'h1C0;
    upd_taken_i = 1'b1;
    upd_target_i = 32'h700;
    upd_pred_i = 1'b0;
    upd_pred_target_i = 32'h0;
    exp_cnt = 0;
    push("mispredict_o_rst", 32'd0);
    push("mispredict_cnt_o_rst", 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    upd_en_i = 1'b0;
    check_mis();
    lookup(32'h1C0, 1'b0, 1'b0, 32'h0);
    lookup(32'h180, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
